// File: rtl/glitch_sequencer_if.sv
// Configuration bus between the command decoder (master) and glitch_sequencer (slave).
interface glitch_sequencer_if #(
  parameter int CTR_W  = 32,
  parameter int ADDR_W = 6
);
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [CTR_W-1:0]  cfg_wdata;
  logic [CTR_W-1:0]  cfg_rdata;
  logic              cfg_err;

  modport master (output cfg_we, cfg_addr, cfg_wdata, input cfg_rdata, cfg_err);
  modport slave  (input cfg_we, cfg_addr, cfg_wdata, output cfg_rdata, cfg_err);
endinterface

// File: rtl/glitch_sequencer.sv
// Multi-slot delay/width glitch sequencer with selectable trigger and optional auto-rearm.
// Define GLITCH_SEQ_TRIG_SYNC_EN to pass i_trig through a 2-flop synchroniser.
module glitch_sequencer #(
  parameter int CTR_W    = 32,
  parameter int N_PULSES = 4,
  parameter int ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  glitch_sequencer_if.slave cfg,
  input  logic              i_arm,
  input  logic              i_disarm,
  input  logic              i_trig,
  input  logic              i_soft_trig,
  output logic              o_glitch,
  output logic              o_armed,
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_shot_cnt
);
  localparam int N_PH      = 2 * N_PULSES;
  localparam int PH_W      = $clog2(N_PH + 1);
  localparam int CTRL_ADDR = N_PH;

  typedef enum logic [2:0] {IDLE, ARMED, DELAY, FIRE, DONE} state_t;

  state_t           state;
  logic [PH_W-1:0]  phase;
  logic [CTR_W-1:0] cnt;

  logic [CTR_W-1:0] delay_r [N_PULSES];
  logic [CTR_W-1:0] width_r [N_PULSES];
  logic [1:0]       trig_mode;
  logic             auto_rearm;
  logic [3:0]       slot_cnt;

  logic             trig_s;
  logic             trig_prev;
  logic             trig_cond;
  logic             trig_hit;
  logic [4:0]       n_act;

  logic [CTR_W-1:0] ph_len [N_PH];
  int               search_start;
  logic             nxt_found;
  logic [PH_W-1:0]  nxt_phase;
  logic [CTR_W-1:0] nxt_len;
  logic             advance;

  logic             addr_ok;
  logic             wr_ok;
  logic [CTR_W-1:0] rd_val;

  // Even phases are delays, odd phases are widths, so slot k owns phases 2k and 2k+1.
  genvar g;
  generate
    for (g = 0; g < N_PULSES; g++) begin : g_len
      assign ph_len[2*g]   = delay_r[g];
      assign ph_len[2*g+1] = width_r[g];
    end
  endgenerate

`ifdef GLITCH_SEQ_TRIG_SYNC_EN
  logic trig_meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trig_meta <= 1'b0;
      trig_s    <= 1'b0;
    end else begin
      trig_meta <= i_trig;
      trig_s    <= trig_meta;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trig_s <= 1'b0;
    end else begin
      trig_s <= i_trig;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trig_prev <= 1'b0;
    end else begin
      trig_prev <= trig_s;
    end
  end

  always_comb begin
    case (trig_mode)
      2'b00:   trig_cond = trig_s & ~trig_prev;
      2'b01:   trig_cond = ~trig_s & trig_prev;
      2'b10:   trig_cond = trig_s;
      default: trig_cond = 1'b0;
    endcase
  end

  assign trig_hit = trig_cond | i_soft_trig;

  always_comb begin
    if (slot_cnt == 4'd0) begin
      n_act = 5'd1;
    end else if (int'(slot_cnt) > N_PULSES) begin
      n_act = 5'(N_PULSES);
    end else begin
      n_act = {1'b0, slot_cnt};
    end
  end

  // Zero-length phases take no cycles: jump straight to the next non-empty phase, or to DONE if none remain.
  always_comb begin
    search_start = (state == ARMED) ? 0 : int'(phase) + 1;
    nxt_found    = 1'b0;
    nxt_phase    = '0;
    nxt_len      = '0;
    for (int i = N_PH - 1; i >= 0; i--) begin
      if (i >= search_start && i < 2 * int'(n_act) && ph_len[i] != '0) begin
        nxt_found = 1'b1;
        nxt_phase = PH_W'(i);
        nxt_len   = ph_len[i];
      end
    end
  end

  assign advance = ((state == ARMED) && trig_hit) ||
                   (((state == DELAY) || (state == FIRE)) && (cnt == CTR_W'(1)));

  assign addr_ok = (int'(cfg.cfg_addr) <= CTRL_ADDR);
  assign wr_ok   = (state == IDLE) || (state == ARMED);

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N_PH; i++) begin
      if (int'(cfg.cfg_addr) == i) begin
        rd_val = ph_len[i];
      end
    end
    if (int'(cfg.cfg_addr) == CTRL_ADDR) begin
      rd_val = CTR_W'({slot_cnt, 1'b0, auto_rearm, trig_mode});
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_PULSES; k++) begin
        delay_r[k] <= '0;
        width_r[k] <= '0;
      end
      trig_mode     <= 2'b00;
      auto_rearm    <= 1'b0;
      slot_cnt      <= 4'd0;
      cfg.cfg_rdata <= '0;
      cfg.cfg_err   <= 1'b0;
    end else begin
      cfg.cfg_rdata <= rd_val;
      cfg.cfg_err   <= cfg.cfg_we & ~(addr_ok & wr_ok);
      if (cfg.cfg_we && addr_ok && wr_ok) begin
        for (int k = 0; k < N_PULSES; k++) begin
          if (int'(cfg.cfg_addr) == 2 * k) begin
            delay_r[k] <= cfg.cfg_wdata;
          end
          if (int'(cfg.cfg_addr) == 2 * k + 1) begin
            width_r[k] <= cfg.cfg_wdata;
          end
        end
        if (int'(cfg.cfg_addr) == CTRL_ADDR) begin
          trig_mode  <= cfg.cfg_wdata[1:0];
          auto_rearm <= cfg.cfg_wdata[2];
          slot_cnt   <= cfg.cfg_wdata[7:4];
        end
      end
    end
  end

  // Outputs are set from the state being entered so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= '0;
      cnt        <= '0;
      o_glitch   <= 1'b0;
      o_armed    <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_shot_cnt <= 16'd0;
    end else begin
      o_done <= 1'b0;
      if (i_disarm) begin
        state    <= IDLE;
        o_glitch <= 1'b0;
        o_armed  <= 1'b0;
        o_busy   <= 1'b0;
      end else if (advance) begin
        o_armed <= 1'b0;
        if (nxt_found) begin
          state    <= nxt_phase[0] ? FIRE : DELAY;
          phase    <= nxt_phase;
          cnt      <= nxt_len;
          o_glitch <= nxt_phase[0];
          o_busy   <= 1'b1;
        end else begin
          state    <= DONE;
          o_glitch <= 1'b0;
          o_busy   <= 1'b0;
          o_done   <= 1'b1;
          if (o_shot_cnt != 16'hFFFF) begin
            o_shot_cnt <= o_shot_cnt + 16'd1;
          end
        end
      end else begin
        case (state)
          IDLE: begin
            if (i_arm) begin
              state   <= ARMED;
              o_armed <= 1'b1;
            end
          end
          DELAY, FIRE: begin
            cnt <= cnt - CTR_W'(1);
          end
          DONE: begin
            state   <= auto_rearm ? ARMED : IDLE;
            o_armed <= auto_rearm;
          end
          default: begin
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_glitch_sequencer.sv
// Randomised self-checking bench for glitch_sequencer against a cycle-offset timing model.
module tb_glitch_sequencer;
  localparam int CTR_W    = 32;
  localparam int N_PULSES = 4;
  localparam int ADDR_W   = 6;
`ifdef GLITCH_SEQ_TRIG_SYNC_EN
  localparam int TRIG_LAT = 2;
`else
  localparam int TRIG_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_arm = 1'b0;
  logic        i_disarm = 1'b0;
  logic        i_trig = 1'b0;
  logic        i_soft_trig = 1'b0;
  logic        o_glitch;
  logic        o_armed;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_shot_cnt;

  glitch_sequencer_if #(.CTR_W(CTR_W), .ADDR_W(ADDR_W)) cfg_bus ();

  glitch_sequencer #(.CTR_W(CTR_W), .N_PULSES(N_PULSES), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg         (cfg_bus),
    .i_arm       (i_arm),
    .i_disarm    (i_disarm),
    .i_trig      (i_trig),
    .i_soft_trig (i_soft_trig),
    .o_glitch    (o_glitch),
    .o_armed     (o_armed),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_shot_cnt  (o_shot_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int       m_delay [N_PULSES];
  int       m_width [N_PULSES];
  int       m_slots;
  bit [1:0] m_mode;
  bit       m_rearm;
  int       m_shots;

  function automatic int model_active();
    if (m_slots == 0) return 1;
    if (m_slots > N_PULSES) return N_PULSES;
    return m_slots;
  endfunction

  // Offsets are measured from the trigger cycle E: the first delay cycle is offset 1.
  function automatic int model_done_off();
    int t = 1;
    for (int k = 0; k < model_active(); k++) t += m_delay[k] + m_width[k];
    return t;
  endfunction

  function automatic bit model_glitch(input int off);
    int t = 1;
    for (int k = 0; k < model_active(); k++) begin
      t += m_delay[k];
      if (off >= t && off < t + m_width[k]) return 1'b1;
      t += m_width[k];
    end
    return 1'b0;
  endfunction

  task automatic cfg_write(input int addr, input logic [31:0] data);
    cfg_bus.cfg_we    = 1'b1;
    cfg_bus.cfg_addr  = ADDR_W'(addr);
    cfg_bus.cfg_wdata = data;
    @(negedge clk);
    cfg_bus.cfg_we    = 1'b0;
  endtask

  task automatic cfg_read(input int addr, output logic [31:0] data);
    cfg_bus.cfg_addr = ADDR_W'(addr);
    @(negedge clk);
    data = cfg_bus.cfg_rdata;
  endtask

  task automatic load_model_cfg();
    for (int k = 0; k < N_PULSES; k++) begin
      cfg_write(2 * k, 32'(m_delay[k]));
      cfg_write(2 * k + 1, 32'(m_width[k]));
    end
    cfg_write(2 * N_PULSES, {24'd0, 4'(m_slots), 1'b0, m_rearm, m_mode});
  endtask

  task automatic settle_trig();
    i_trig = (m_mode == 2'b01);
    repeat (4) @(negedge clk);
  endtask

  task automatic arm();
    i_arm = 1'b1;
    @(negedge clk);
    i_arm = 1'b0;
  endtask

  task automatic disarm();
    i_disarm = 1'b1;
    @(negedge clk);
    i_disarm = 1'b0;
  endtask

  task automatic fire(output int cur_off);
    if (m_mode == 2'b11) begin
      i_soft_trig = 1'b1;
      cur_off = 0;
    end else begin
      i_trig = (m_mode == 2'b01) ? 1'b0 : 1'b1;
      cur_off = -TRIG_LAT;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_glitch, o_armed, o_busy, o_done} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b exp=0000", {o_glitch, o_armed, o_busy, o_done});
    end
    checks++;
    if (o_shot_cnt !== 16'd0 || cfg_bus.cfg_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_cnt got shot=%0h err=%0b exp 0/0", o_shot_cnt, cfg_bus.cfg_err);
    end
    rst_n = 1'b1;
    m_shots = 0;
    @(negedge clk);
  endtask

  task automatic test_single_pulse();
    int cur, done;
    m_mode = 2'b00; m_rearm = 1'b0; m_slots = 1;
    for (int k = 0; k < N_PULSES; k++) begin m_delay[k] = 0; m_width[k] = 0; end
    m_delay[0] = 5; m_width[0] = 3;
    load_model_cfg();
    settle_trig();
    arm();
    fire(cur);
    done = model_done_off();
    for (int off = cur + 1; off <= done + 1; off++) begin
      @(negedge clk);
      i_soft_trig = 1'b0;
      checks++;
      if (o_glitch !== model_glitch(off)) begin
        failures++;
        $display("[TB] FAIL single_glitch off=%0d got=%0b exp=%0b", off, o_glitch, model_glitch(off));
      end
      checks++;
      if (o_done !== 1'(off == done)) begin
        failures++;
        $display("[TB] FAIL single_done off=%0d got=%0b exp=%0b", off, o_done, off == done);
      end
      checks++;
      if (o_busy !== 1'(off >= 1 && off < done) || o_armed !== 1'(off <= 0)) begin
        failures++;
        $display("[TB] FAIL single_state off=%0d got busy=%0b armed=%0b", off, o_busy, o_armed);
      end
    end
    m_shots++;
    checks++;
    if (o_shot_cnt !== 16'(m_shots)) begin
      failures++;
      $display("[TB] FAIL single_shots got=%0d exp=%0d", o_shot_cnt, m_shots);
    end
    i_trig = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_three_slots();
    int cur, done;
    m_mode = 2'b00; m_rearm = 1'b0; m_slots = 3;
    m_delay[0] = 2; m_delay[1] = 4; m_delay[2] = 0; m_delay[3] = 0;
    m_width[0] = 1; m_width[1] = 0; m_width[2] = 2; m_width[3] = 0;
    load_model_cfg();
    settle_trig();
    arm();
    fire(cur);
    done = model_done_off();
    for (int off = cur + 1; off <= done + 1; off++) begin
      @(negedge clk);
      checks++;
      if (o_glitch !== model_glitch(off)) begin
        failures++;
        $display("[TB] FAIL three_glitch off=%0d got=%0b exp=%0b", off, o_glitch, model_glitch(off));
      end
      checks++;
      if (o_done !== 1'(off == done)) begin
        failures++;
        $display("[TB] FAIL three_done off=%0d got=%0b exp=%0b", off, o_done, off == done);
      end
    end
    m_shots++;
    i_trig = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random_sequences();
    int cur, done;
    for (int iter = 0; iter < 10; iter++) begin
      m_mode  = 2'($urandom_range(0, 3));
      m_rearm = 1'b0;
      m_slots = $urandom_range(0, 7);
      for (int k = 0; k < N_PULSES; k++) begin
        m_delay[k] = $urandom_range(0, 5);
        m_width[k] = $urandom_range(0, 3);
      end
      load_model_cfg();
      settle_trig();
      arm();
      if (m_mode == 2'b11) begin
        i_trig = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (o_armed !== 1'b1 || o_busy !== 1'b0) begin
          failures++;
          $display("[TB] FAIL soft_only_pin got armed=%0b busy=%0b exp 1/0", o_armed, o_busy);
        end
        i_trig = 1'b0;
        repeat (2) @(negedge clk);
      end
      fire(cur);
      done = model_done_off();
      for (int off = cur + 1; off <= done + 1; off++) begin
        @(negedge clk);
        i_soft_trig = 1'b0;
        checks++;
        if (o_glitch !== model_glitch(off)) begin
          failures++;
          $display("[TB] FAIL rand_glitch iter=%0d mode=%0d off=%0d got=%0b exp=%0b",
                   iter, m_mode, off, o_glitch, model_glitch(off));
        end
        checks++;
        if (o_done !== 1'(off == done)) begin
          failures++;
          $display("[TB] FAIL rand_done iter=%0d off=%0d got=%0b exp=%0b", iter, off, o_done, off == done);
        end
        checks++;
        if (o_busy !== 1'(off >= 1 && off < done) || o_armed !== 1'(off <= 0)) begin
          failures++;
          $display("[TB] FAIL rand_state iter=%0d off=%0d got busy=%0b armed=%0b", iter, off, o_busy, o_armed);
        end
      end
      m_shots++;
      checks++;
      if (o_shot_cnt !== 16'(m_shots)) begin
        failures++;
        $display("[TB] FAIL rand_shots iter=%0d got=%0d exp=%0d", iter, o_shot_cnt, m_shots);
      end
      i_trig = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_disarm();
    int cur;
    int shots_before;
    bit saw_done;
    m_mode = 2'b00; m_rearm = 1'b0; m_slots = 1;
    for (int k = 0; k < N_PULSES; k++) begin m_delay[k] = 0; m_width[k] = 0; end
    m_delay[0] = 2; m_width[0] = 6;
    load_model_cfg();
    settle_trig();
    shots_before = m_shots;
    arm();
    fire(cur);
    for (int off = cur + 1; off <= 4; off++) @(negedge clk);
    checks++;
    if (o_glitch !== 1'b1) begin
      failures++;
      $display("[TB] FAIL disarm_pre got glitch=%0b exp=1", o_glitch);
    end
    i_arm = 1'b1;
    disarm();
    i_arm = 1'b0;
    checks++;
    if ({o_glitch, o_busy, o_armed} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL disarm_post got glitch/busy/armed=%b exp=000", {o_glitch, o_busy, o_armed});
    end
    saw_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (o_done === 1'b1 || o_glitch === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || o_shot_cnt !== 16'(shots_before)) begin
      failures++;
      $display("[TB] FAIL disarm_quiet got activity=%0b shots=%0d exp 0/%0d", saw_done, o_shot_cnt, shots_before);
    end
    i_trig = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cfg_guards();
    int cur;
    logic [31:0] v;
    m_mode = 2'b00; m_rearm = 1'b0; m_slots = 1;
    for (int k = 0; k < N_PULSES; k++) begin m_delay[k] = 0; m_width[k] = 0; end
    m_delay[0] = 20; m_width[0] = 2;
    load_model_cfg();
    cfg_write(2, 32'hDEADBEEF);
    checks++;
    if (cfg_bus.cfg_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL cfg_ok_err got=%0b exp=0", cfg_bus.cfg_err);
    end
    cfg_read(2, v);
    checks++;
    if (v !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL cfg_readback got=%h exp=deadbeef", v);
    end
    cfg_read(0, v);
    checks++;
    if (v !== 32'd20) begin
      failures++;
      $display("[TB] FAIL cfg_b2b_delay0 got=%0d exp=20", v);
    end
    cfg_write(2 * N_PULSES + 1, 32'h1);
    checks++;
    if (cfg_bus.cfg_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL cfg_bad_addr_err got=%0b exp=1", cfg_bus.cfg_err);
    end
    cfg_read(2 * N_PULSES + 1, v);
    checks++;
    if (v !== 32'd0) begin
      failures++;
      $display("[TB] FAIL cfg_bad_addr_read got=%h exp=0", v);
    end
    settle_trig();
    arm();
    fire(cur);
    repeat (TRIG_LAT + 3) @(negedge clk);
    checks++;
    if (o_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL cfg_in_delay got busy=%0b exp=1", o_busy);
    end
    cfg_write(2, 32'h1234);
    checks++;
    if (cfg_bus.cfg_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL cfg_busy_err got=%0b exp=1", cfg_bus.cfg_err);
    end
    disarm();
    cfg_read(2, v);
    checks++;
    if (v !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL cfg_busy_unchanged got=%h exp=deadbeef", v);
    end
    i_trig = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_big_delay();
    cfg_write(0, 32'hFFFF_FFFF);
    cfg_write(1, 32'd1);
    cfg_write(2 * N_PULSES, 32'h0000_0013);
    arm();
    i_soft_trig = 1'b1;
    @(negedge clk);
    i_soft_trig = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (o_busy !== 1'b1 || o_glitch !== 1'b0) begin
      failures++;
      $display("[TB] FAIL big_delay got busy=%0b glitch=%0b exp 1/0", o_busy, o_glitch);
    end
    disarm();
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL big_delay_disarm got busy=%0b exp=0", o_busy);
    end
  endtask

  task automatic test_level_rearm(input int n_seq);
    int cur, done, period, rel;
    m_mode = 2'b10; m_rearm = 1'b1; m_slots = 1;
    for (int k = 0; k < N_PULSES; k++) begin m_delay[k] = 0; m_width[k] = 0; end
    m_delay[0] = $urandom_range(0, 3);
    m_width[0] = $urandom_range(1, 2);
    i_trig = 1'b0;
    load_model_cfg();
    repeat (2) @(negedge clk);
    arm();
    fire(cur);
    done = model_done_off();
    period = done + 1;
    for (int off = cur + 1; off <= n_seq * period; off++) begin
      @(negedge clk);
      rel = (off <= 0) ? off : ((off - 1) % period) + 1;
      checks++;
      if (o_glitch !== model_glitch(rel) || o_done !== 1'(rel == done)) begin
        failures++;
        $display("[TB] FAIL level_wave off=%0d got glitch=%0b done=%0b exp %0b/%0b",
                 off, o_glitch, o_done, model_glitch(rel), rel == done);
      end
      checks++;
      if (o_armed !== 1'(rel <= 0 || rel == period)) begin
        failures++;
        $display("[TB] FAIL level_armed off=%0d got=%0b", off, o_armed);
      end
      if (rel == done) begin
        if (m_shots < 65535) m_shots++;
        checks++;
        if (o_shot_cnt !== 16'(m_shots)) begin
          failures++;
          $display("[TB] FAIL level_shots got=%0d exp=%0d", o_shot_cnt, m_shots);
        end
      end
    end
    disarm();
    i_trig = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_shot_saturation();
    force dut.o_shot_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.o_shot_cnt;
    @(negedge clk);
    m_shots = 65534;
    checks++;
    if (o_shot_cnt !== 16'hFFFE) begin
      failures++;
      $display("[TB] FAIL sat_preload got=%h exp=fffe", o_shot_cnt);
    end
    test_level_rearm(3);
  endtask

  task automatic test_reset_mid();
    int cur;
    logic [31:0] v;
    m_mode = 2'b00; m_rearm = 1'b0; m_slots = 1;
    for (int k = 0; k < N_PULSES; k++) begin m_delay[k] = 0; m_width[k] = 0; end
    m_delay[0] = 10; m_width[0] = 2;
    load_model_cfg();
    settle_trig();
    arm();
    fire(cur);
    repeat (TRIG_LAT + 3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_glitch, o_armed, o_busy, o_done} !== 4'b0000 || o_shot_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL rst_mid_out got flags=%b shots=%0d exp 0000/0",
               {o_glitch, o_armed, o_busy, o_done}, o_shot_cnt);
    end
    rst_n = 1'b1;
    i_trig = 1'b0;
    m_shots = 0;
    cfg_read(2 * N_PULSES, v);
    checks++;
    if (v !== 32'd0) begin
      failures++;
      $display("[TB] FAIL rst_mid_ctrl got=%h exp=0", v);
    end
    cfg_read(0, v);
    checks++;
    if (v !== 32'd0) begin
      failures++;
      $display("[TB] FAIL rst_mid_delay got=%h exp=0", v);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    cfg_bus.cfg_we    = 1'b0;
    cfg_bus.cfg_addr  = '0;
    cfg_bus.cfg_wdata = '0;
    @(negedge clk);
    test_reset();
    test_single_pulse();
    test_three_slots();
    test_random_sequences();
    test_disarm();
    test_cfg_guards();
    test_big_delay();
    test_level_rearm(3);
    test_shot_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
